operand_forward: RTL

- Sits directly downstream of the register file; consumes its registered read data (data_out_a/data_out_b) and delivers final source operands to the execute stage.
- Corrects read-after-write hazards: the register file returns pre-write data when a write lands in the same edge as the read, or while the read data is still in flight.
- Tracks in-flight reads and recent writebacks, then muxes in the newest value. Output is registered.

---
 rtl/operand_forward.sv | 120 ++++++++++++
 1 files changed

// File: rtl/operand_forward.sv
// Forwards RAW-hazard data into register-file read results; 2-cycle issue-to-operand latency, full throughput.
// clk_enable=0 freezes all state. OPERAND_FORWARD_STATS_EN adds a saturating fwd_count output.
module operand_forward #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              flush,
  input  logic              rd_issue,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
`ifdef OPERAND_FORWARD_STATS_EN
  ,
  output logic [15:0]       fwd_count
`endif
);

  logic              r_s_valid;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic              r_h_valid;
  logic [ADDR_W-1:0] r_h_rd;
  logic [DATA_W-1:0] r_h_data;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;

  logic              w_wr_nz;
  logic              w_live;
  logic              w_a_wb;
  logic              w_a_h;
  logic              w_b_wb;
  logic              w_b_h;
  logic              w_fwd;
  logic              w_out_fire;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  assign w_wr_nz    = (wb_rd != 5'd0);
  assign w_live     = clk_enable & wb_en & w_wr_nz;
  assign w_out_fire = r_s_valid & ~flush;

  // x0 reads never forward; matching uses only the physical index bits.
  assign w_a_wb = w_live    && (r_rs1 != 5'd0) && (wb_rd[ADDR_W-1:0] == r_rs1[ADDR_W-1:0]);
  assign w_a_h  = r_h_valid && (r_rs1 != 5'd0) && (r_h_rd == r_rs1[ADDR_W-1:0]);
  assign w_b_wb = w_live    && (r_rs2 != 5'd0) && (wb_rd[ADDR_W-1:0] == r_rs2[ADDR_W-1:0]);
  assign w_b_h  = r_h_valid && (r_rs2 != 5'd0) && (r_h_rd == r_rs2[ADDR_W-1:0]);
  assign w_fwd  = w_a_wb | w_a_h | w_b_wb | w_b_h;

  always_comb begin
    w_op_a = reg_a;
    if (r_rs1 == 5'd0) w_op_a = '0;
    else if (w_a_wb)   w_op_a = wb_data;
    else if (w_a_h)    w_op_a = r_h_data;

    w_op_b = reg_b;
    if (r_rs2 == 5'd0) w_op_b = '0;
    else if (w_b_wb)   w_op_b = wb_data;
    else if (w_b_h)    w_op_b = r_h_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid  <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_h_valid  <= 1'b0;
      r_h_rd     <= '0;
      r_h_data   <= '0;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else if (clk_enable) begin
      r_s_valid  <= rd_issue & ~flush;
      r_rs1      <= rs1;
      r_rs2      <= rs2;
      // The register file reads the pre-write value on this edge, so keep the write.
      r_h_valid  <= wb_en & w_wr_nz;
      r_h_rd     <= wb_rd[ADDR_W-1:0];
      r_h_data   <= wb_data;
      r_op_valid <= w_out_fire;
      if (w_out_fire) begin
        r_op_a <= w_op_a;
        r_op_b <= w_op_b;
      end
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;

`ifdef OPERAND_FORWARD_STATS_EN
  logic [15:0] r_fwd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_count <= '0;
    end else if (clk_enable && w_out_fire && w_fwd && (r_fwd_count != 16'hFFFF)) begin
      r_fwd_count <= r_fwd_count + 16'd1;
    end
  end

  assign fwd_count = r_fwd_count;
`else
  logic w_unused;
  assign w_unused = w_fwd;
`endif

endmodule
